uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receive engine for the host link. It consumes the 16x oversample strobe from the existing baud generator and samples the asynchronous rx line at mid-bit. It deframes 8N1 characters, LSB first, and hands each byte to the command decoder over a valid/ready interface. Framing errors and overruns are flagged as one-cycle pulses.

Parameters:
OS, 16, oversample ticks per bit; must match the baud generator; even, >= 4
DATA_BITS, 8, data bits per frame; legal range 5..9
TCW, derived = $clog2(OS), width of the tick counter
BCW, derived = max(1, $clog2(DATA_BITS)), width of the bit counter

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
os_tick  in  1  one-CLK strobe at OS x baud, from the baud generator
rx  in  1  asynchronous serial line; idles high
rx_data  out  DATA_BITS  received byte; stable while rx_valid=1
rx_valid  out  1  byte available; held until accepted
rx_ready  in  1  consumer accepts; a transfer occurs when rx_valid && rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled low
overrun  out  1  one-cycle pulse: new byte dropped because the previous byte was not accepted
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counters=0; shift register=0.
  - rx_data=0; rx_valid=0; frame_err=0; overrun=0; busy=0.
  - Both synchronizer flops=1, so the line reads idle.
  - Reset mid-frame abandons the frame silently.
- rx passes through a 2-FF synchronizer. All decisions use the synchronized rx_s, and only on CLK edges where os_tick=1. Between ticks, state and counters hold.
- FSM:
  - IDLE: on os_tick with rx_s=0 -> START, tick_cnt=0.
  - START: on each os_tick, if tick_cnt==OS/2-1, check rx_s. If rx_s=0 -> DATA, tick_cnt=0, bit_cnt=0. If rx_s=1 -> IDLE (glitch rejected, no flags). Otherwise tick_cnt++.
  - DATA: on each os_tick, if tick_cnt==OS-1, shift right with rx_s entering the MSB and set tick_cnt=0. If bit_cnt==DATA_BITS-1 -> STOP, else bit_cnt++. Otherwise tick_cnt++.
  - STOP: on os_tick with tick_cnt==OS-1, sample rx_s and go to IDLE. rx_s=1 delivers the byte; rx_s=0 pulses frame_err and discards the byte.
- Sample points are counted in os_ticks after the detecting tick (tick 0):
  - start check at tick OS/2;
  - data bit k at OS*(k+1)+OS/2;
  - stop bit at OS*(DATA_BITS+1)+OS/2 (152 for defaults).
- Frame completion returns the FSM to IDLE at mid-stop-bit, so a start edge immediately following the stop bit is caught.
- Delivery timing: rx_data and rx_valid update on the same CLK edge as the stop sample, so rx_valid is visible the following cycle.
- Delivery when rx_valid=0, or rx_valid=1 with rx_ready=1 in the same cycle: load rx_data, rx_valid=1, no overrun.
- Delivery when rx_valid=1 and rx_ready=0: rx_data keeps the old byte, rx_valid stays 1, overrun pulses for 1 cycle.
- Acceptance: rx_valid && rx_ready with no delivery in that cycle -> rx_valid=0 next cycle.
- Frame error with a pending byte: frame_err pulses; rx_valid and rx_data are untouched; no overrun.
- frame_err and overrun are never both high in the same cycle.
- rx_ready is ignored while rx_valid=0.
- Counters never wrap: tick_cnt resets at its terminal value; bit_cnt stops at DATA_BITS-1.

Decomposition:
- uart_pkg holds:
  - the state enum constants IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - defaults UART_OS=16 and UART_DATA_BITS=8, shared with the baud generator.
- One sub-module: sync_2ff (2-flop synchronizer, reset value parameter = 1). It is reusable for other async inputs.

Test Plan:
- Common setup: the existing baud generator at FCLK=100 MHz, BAUD=115200 (54 CLK per os_tick) drives os_tick. The bench drives rx with an exact 8N1 model.
1. Send 0x55 with rx_ready=1 -> rx_valid high exactly 1 cycle, rx_data=0x55, no flags, busy falls at mid-stop-bit.
2. Send 0xA3 then 0x3C back-to-back with rx_ready=0 -> rx_data=0xA3 held, overrun pulse at the 0x3C stop sample. Then raise rx_ready for 1 cycle -> rx_valid=0.
3. Send 0xFF with the stop bit driven 0 -> frame_err 1-cycle pulse, rx_valid stays 0. A following good 0x12 is received correctly.
4. Pull rx low for 4 os_ticks, then high -> FSM returns to IDLE after the start check, no rx_valid, no frame_err.
5. Assert rst_n=0 for 3 CLK during data bit 3 of 0xC7 -> all outputs 0 immediately. After release, the next frame 0x81 is received as 0x81.
6. Stretch every bit to 16.5 os_ticks (+3%), send 0x96 -> received 0x96, no flags. Repeat at -3% with the same result.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

   localparam int UART_OS        = 16;
   localparam int UART_DATA_BITS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous inputs
module sync_2ff #(
   parameter int   WIDTH   = 1,
   parameter logic RST_VAL = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= {WIDTH{RST_VAL}};
         r_sync <= {WIDTH{RST_VAL}};
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling on the oversample strobe
module uart_rx
   import uart_pkg::*;
#(
   parameter int OS        = UART_OS,
   parameter int DATA_BITS = UART_DATA_BITS
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_os_tick,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic                 o_frame_err,
   output logic                 o_overrun,
   output logic                 o_busy
);

   localparam int TCW = $clog2(OS);
   localparam int BCW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;

   localparam logic [TCW-1:0] TC_MID = TCW'(OS / 2 - 1);
   localparam logic [TCW-1:0] TC_END = TCW'(OS - 1);
   localparam logic [BCW-1:0] BC_END = BCW'(DATA_BITS - 1);

   uart_state_t          r_state;
   logic [TCW-1:0]       r_tick_cnt;
   logic [BCW-1:0]       r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rx_valid;
   logic                 r_frame_err;
   logic                 r_overrun;
   logic                 w_rx_s;
   logic                 w_pending;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_rx_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_rx),
      .o_q     (w_rx_s)
   );

   // A byte still held at the output that the consumer is not taking this cycle
   assign w_pending = r_rx_valid && !i_rx_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
         if (r_rx_valid && i_rx_ready) begin
            r_rx_valid <= 1'b0;
         end
         if (i_os_tick) begin
            case (r_state)
               IDLE: begin
                  if (!w_rx_s) begin
                     r_state    <= START;
                     r_tick_cnt <= '0;
                  end
               end
               START: begin
                  if (r_tick_cnt == TC_MID) begin
                     r_tick_cnt <= '0;
                     r_bit_cnt  <= '0;
                     r_state    <= w_rx_s ? IDLE : DATA;
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               DATA: begin
                  if (r_tick_cnt == TC_END) begin
                     r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                     r_tick_cnt <= '0;
                     if (r_bit_cnt == BC_END) begin
                        r_state <= STOP;
                     end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               STOP: begin
                  if (r_tick_cnt == TC_END) begin
                     // Leave at mid-stop so a start edge right after the stop bit is caught
                     r_state    <= IDLE;
                     r_tick_cnt <= '0;
                     if (!w_rx_s) begin
                        r_frame_err <= 1'b1;
                     end else if (w_pending) begin
                        r_overrun <= 1'b1;
                     end else begin
                        r_rx_data  <= r_shift;
                        r_rx_valid <= 1'b1;
                     end
                  end else begin
                     r_tick_cnt <= r_tick_cnt + 1'b1;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_rx_data   = r_rx_data;
   assign o_rx_valid  = r_rx_valid;
   assign o_frame_err = r_frame_err;
   assign o_overrun   = r_overrun;
   assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int OS      = 16;
   localparam int DB      = 8;
   localparam int DIV     = 6;
   localparam int BIT_CLK = OS * DIV;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       os_tick  = 1'b0;
   logic       rx       = 1'b1;
   logic       rx_ready = 1'b0;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       o_frame_err;
   logic       o_overrun;
   logic       o_busy;

   int n_tests = 0;
   int n_fail  = 0;

   uart_rx dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_os_tick   (os_tick),
      .i_rx        (rx),
      .o_rx_data   (o_rx_data),
      .o_rx_valid  (o_rx_valid),
      .i_rx_ready  (rx_ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 30)
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Baud generator stand-in: one-cycle strobe every DIV clocks
   initial begin
      int c;
      c = 0;
      forever begin
         @(negedge clk);
         os_tick = (c == DIV - 1);
         c = (c == DIV - 1) ? 0 : c + 1;
      end
   end

   // Reference model: line seen through two flops, samples at fixed tick offsets after detection
   logic       m_s1 = 1'b1, m_s2 = 1'b1;
   bit         m_active = 1'b0;
   int         m_n = 0, m_t0 = 0, m_d, m_k;
   logic [7:0] m_shift = '0;
   logic [7:0] e_data = '0;
   bit         e_valid = 1'b0, e_fe = 1'b0, e_ov = 1'b0, m_pend;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_s1 = 1'b1; m_s2 = 1'b1; m_active = 1'b0; m_n = 0; m_t0 = 0;
         m_shift = '0; e_data = '0; e_valid = 1'b0; e_fe = 1'b0; e_ov = 1'b0;
      end else begin
         e_fe = 1'b0;
         e_ov = 1'b0;
         m_pend = e_valid && !rx_ready;
         if (e_valid && rx_ready) e_valid = 1'b0;
         if (os_tick) begin
            if (!m_active) begin
               if (!m_s2) begin
                  m_active = 1'b1;
                  m_t0 = m_n;
               end
            end else begin
               m_d = m_n - m_t0;
               if (m_d == OS / 2) begin
                  if (m_s2) m_active = 1'b0;
               end else if (m_d > OS / 2 && (m_d - OS / 2) % OS == 0) begin
                  m_k = (m_d - OS / 2) / OS - 1;
                  if (m_k < DB) begin
                     m_shift[m_k] = m_s2;
                  end else begin
                     m_active = 1'b0;
                     if (!m_s2) e_fe = 1'b1;
                     else if (m_pend) e_ov = 1'b1;
                     else begin
                        e_data = m_shift;
                        e_valid = 1'b1;
                     end
                  end
               end
            end
            m_n++;
         end
         m_s2 = m_s1;
         m_s1 = rx;
      end
   end

   // Per-cycle compare plus event counters for the directed literal checks
   int         cnt_del = 0, cnt_vcyc = 0, cnt_fe = 0, cnt_ov = 0, cnt_busy = 0;
   logic [7:0] last_data = '0;
   bit         prev_valid = 1'b0, prev_xfer = 1'b0;

   initial forever begin
      @(posedge clk);
      #2;
      chk("rx_valid", {31'd0, o_rx_valid}, {31'd0, e_valid});
      chk("rx_data", {24'd0, o_rx_data}, {24'd0, e_data});
      chk("frame_err", {31'd0, o_frame_err}, {31'd0, e_fe});
      chk("overrun", {31'd0, o_overrun}, {31'd0, e_ov});
      chk("busy", {31'd0, o_busy}, {31'd0, m_active});
      if (o_rx_valid && (!prev_valid || prev_xfer)) begin
         cnt_del++;
         last_data = o_rx_data;
      end
      if (o_rx_valid) cnt_vcyc++;
      if (o_frame_err) cnt_fe++;
      if (o_overrun) cnt_ov++;
      if (o_busy) cnt_busy++;
      prev_valid = o_rx_valid;
      prev_xfer = o_rx_valid && rx_ready;
   end

   task automatic clr();
      cnt_del = 0; cnt_vcyc = 0; cnt_fe = 0; cnt_ov = 0; cnt_busy = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk) rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop, input int bclk, input int abort_at);
      logic [9:0] f;
      int t;
      f = {stop, b, 1'b0};
      t = 0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < bclk; c++) begin
            @(negedge clk);
            if (t == abort_at) begin
               rx = 1'b1;
               return;
            end
            rx = f[i];
            t++;
         end
      end
   endtask

   bit rnd_en = 1'b0;
   initial forever begin
      @(negedge clk);
      if (rnd_en) rx_ready = $urandom_range(0, 1) == 1;
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_valid", {31'd0, o_rx_valid}, 32'd0);
      chk("reset_busy", {31'd0, o_busy}, 32'd0);
      chk("reset_data", {24'd0, o_rx_data}, 32'd0);
      chk("reset_flags", {30'd0, o_frame_err, o_overrun}, 32'd0);
      rst_n = 1'b1;
      idle(2 * BIT_CLK);

      // 1: single byte, consumer always ready
      rx_ready = 1'b1;
      clr();
      idle($urandom_range(0, 3 * DIV));
      send_frame(8'h55, 1'b1, BIT_CLK, -1);
      chk("t1_busy_after", {31'd0, o_busy}, 32'd0);
      idle(BIT_CLK);
      chk("t1_valid_cycles", cnt_vcyc, 1);
      chk("t1_data", {24'd0, last_data}, 32'h55);
      chk("t1_flags", cnt_fe + cnt_ov, 0);

      // 2: back-to-back with consumer stalled
      rx_ready = 1'b0;
      clr();
      idle($urandom_range(0, 3 * DIV));
      send_frame(8'hA3, 1'b1, BIT_CLK, -1);
      send_frame(8'h3C, 1'b1, BIT_CLK, -1);
      idle(BIT_CLK);
      chk("t2_valid_held", {31'd0, o_rx_valid}, 32'd1);
      chk("t2_data_held", {24'd0, o_rx_data}, 32'hA3);
      chk("t2_overrun_cnt", cnt_ov, 1);
      chk("t2_deliveries", cnt_del, 1);
      @(negedge clk) rx_ready = 1'b1;
      @(negedge clk) rx_ready = 1'b0;
      @(posedge clk);
      #2;
      chk("t2_accept", {31'd0, o_rx_valid}, 32'd0);

      // 3: framing error, then a good byte
      rx_ready = 1'b1;
      clr();
      send_frame(8'hFF, 1'b0, BIT_CLK, -1);
      idle(3 * BIT_CLK);
      chk("t3_fe_cnt", cnt_fe, 1);
      chk("t3_no_valid", cnt_vcyc, 0);
      clr();
      send_frame(8'h12, 1'b1, BIT_CLK, -1);
      idle(BIT_CLK);
      chk("t3_good_data", {24'd0, last_data}, 32'h12);
      chk("t3_good_cnt", cnt_del, 1);

      // 4: short low glitch rejected at the start check
      clr();
      repeat (4 * DIV) @(negedge clk) rx = 1'b0;
      idle(2 * BIT_CLK);
      chk("t4_no_valid", cnt_vcyc, 0);
      chk("t4_no_fe", cnt_fe, 0);
      chk("t4_saw_busy", {31'd0, cnt_busy > 0}, 32'd1);
      chk("t4_idle", {31'd0, o_busy}, 32'd0);

      // 5: reset in the middle of data bit 3
      clr();
      send_frame(8'hC7, 1'b1, BIT_CLK, 4 * BIT_CLK + BIT_CLK / 2);
      chk("t5_busy_pre", {31'd0, o_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_outs", {20'd0, o_rx_data, o_rx_valid, o_frame_err, o_overrun, o_busy}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(BIT_CLK);
      clr();
      send_frame(8'h81, 1'b1, BIT_CLK, -1);
      idle(BIT_CLK);
      chk("t5_data", {24'd0, last_data}, 32'h81);
      chk("t5_cnt", cnt_del, 1);

      // 6: bit length +3% and -3%
      for (int s = 0; s < 2; s++) begin
         clr();
         idle($urandom_range(0, 3 * DIV));
         send_frame(8'h96, 1'b1, (s == 0) ? BIT_CLK + DIV / 2 : BIT_CLK - DIV / 2, -1);
         idle(BIT_CLK);
         chk("t6_data", {24'd0, last_data}, 32'h96);
         chk("t6_flags", cnt_fe + cnt_ov + cnt_del, 1);
      end

      // Random traffic against the model
      rnd_en = 1'b1;
      for (int i = 0; i < 16; i++) begin
         logic [7:0] b;
         logic       st;
         b = 8'($urandom);
         st = $urandom_range(0, 7) != 0;
         send_frame(b, st, $urandom_range(BIT_CLK - DIV / 2, BIT_CLK + DIV / 2), -1);
         if (!st) idle(BIT_CLK);
         idle($urandom_range(0, BIT_CLK));
      end
      rnd_en = 1'b0;
      @(negedge clk) rx_ready = 1'b1;
      idle(2 * BIT_CLK);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
